// File: rtl/diff_window_stats.sv
// Windowed statistics over the magnitude-difference stream: per window it reports
// the sum, the maximum, the equality-marker count and the sample count, held on a valid/ready port.
module diff_window_stats #(
  parameter int                DATA_W  = 8,
  parameter int                WIN_LEN = 16,
  parameter int                SUM_W   = 12,
  parameter int                CNT_W   = 5,
  parameter logic [DATA_W-1:0] EQ_CODE = 8'hFF
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_eq_cnt,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [SUM_W-1:0]  sum_acc_r;
  logic [DATA_W-1:0] max_acc_r;
  logic [CNT_W-1:0]  eq_acc_r;
  logic [CNT_W-1:0]  cnt_acc_r;

  logic [SUM_W-1:0]  sum_nxt_s;
  logic [DATA_W-1:0] max_nxt_s;
  logic [CNT_W-1:0]  eq_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;

  logic accept_s;
  logic take_s;
  logic full_close_s;
  logic flush_close_s;
  logic close_s;

  // Saturating accumulate: clamps at all-ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [SUM_W:0] t;
    t = {1'b0, a} + {{(SUM_W + 1 - DATA_W){1'b0}}, b};
    if (t[SUM_W]) begin
      sat_add = {SUM_W{1'b1}};
    end else begin
      sat_add = t[SUM_W-1:0];
    end
  endfunction

  assign in_ready      = (state_r == ACCUM);
  assign accept_s      = in_valid & in_ready;
  assign take_s        = out_valid & out_ready;
  assign full_close_s  = accept_s & (cnt_nxt_s == CNT_W'(WIN_LEN));
  assign flush_close_s = flush & ((cnt_acc_r != {CNT_W{1'b0}}) | accept_s);
  assign close_s       = (state_r == ACCUM) & (full_close_s | flush_close_s);

  // Accumulator update for the current cycle; in_data is only looked at on accept.
  always_comb begin
    sum_nxt_s = sum_acc_r;
    max_nxt_s = max_acc_r;
    eq_nxt_s  = eq_acc_r;
    cnt_nxt_s = cnt_acc_r;
    if (accept_s) begin
      cnt_nxt_s = cnt_acc_r + CNT_W'(1);
      if (in_data == EQ_CODE) begin
        eq_nxt_s = eq_acc_r + CNT_W'(1);
      end else begin
        sum_nxt_s = sat_add(sum_acc_r, in_data);
        if (in_data > max_acc_r) begin
          max_nxt_s = in_data;
        end else begin
          max_nxt_s = max_acc_r;
        end
      end
    end else begin
      cnt_nxt_s = cnt_acc_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (close_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (take_s) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulators: run in ACCUM, freeze in HOLD, clear when the result is taken.
  always_ff @(posedge clk) begin
    if (RESET || take_s) begin
      sum_acc_r <= {SUM_W{1'b0}};
      max_acc_r <= {DATA_W{1'b0}};
      eq_acc_r  <= {CNT_W{1'b0}};
      cnt_acc_r <= {CNT_W{1'b0}};
    end else if (state_r == ACCUM) begin
      sum_acc_r <= sum_nxt_s;
      max_acc_r <= max_nxt_s;
      eq_acc_r  <= eq_nxt_s;
      cnt_acc_r <= cnt_nxt_s;
    end
  end

  // Result registers, loaded with the closing sample already folded in.
  always_ff @(posedge clk) begin
    if (RESET) begin
      out_valid  <= 1'b0;
      out_sum    <= {SUM_W{1'b0}};
      out_max    <= {DATA_W{1'b0}};
      out_eq_cnt <= {CNT_W{1'b0}};
      out_count  <= {CNT_W{1'b0}};
    end else if (close_s) begin
      out_valid  <= 1'b1;
      out_sum    <= sum_nxt_s;
      out_max    <= max_nxt_s;
      out_eq_cnt <= eq_nxt_s;
      out_count  <= cnt_nxt_s;
    end else if (take_s) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diff_window_stats.sv
// Bench for diff_window_stats: queue-based window model checked every cycle,
// directed test-plan windows pinned with literal results, then randomized traffic.
module tb_diff_window_stats;
  localparam int                DATA_W  = 8;
  localparam int                WIN_LEN = 16;
  localparam int                SUM_W   = 12;
  localparam int                CNT_W   = 5;
  localparam logic [DATA_W-1:0] EQ_CODE = 8'hFF;
  localparam int                SUM_MAX = (1 << SUM_W) - 1;

  logic              clk = 1'b0;
  logic              RESET = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = 8'h00;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]  out_eq_cnt;
  logic [CNT_W-1:0]  out_count;

  int n_cmp = 0;
  int n_bad = 0;

  diff_window_stats #(
    .DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .SUM_W(SUM_W), .CNT_W(CNT_W), .EQ_CODE(EQ_CODE)
  ) dut (
    .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_max(out_max), .out_eq_cnt(out_eq_cnt), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window kept as a plain list of accepted samples
  logic [DATA_W-1:0] win_q[$];
  bit m_init = 1'b0;
  bit m_hold = 1'b0;
  bit m_valid = 1'b0;
  int m_sum = 0, m_max = 0, m_eq = 0, m_cnt = 0;

  always @(posedge clk) begin
    if (RESET) begin
      win_q.delete();
      m_hold = 1'b0; m_valid = 1'b0;
      m_sum = 0; m_max = 0; m_eq = 0; m_cnt = 0;
      m_init = 1'b1;
    end else if (!m_hold) begin
      if (in_valid) win_q.push_back(in_data);
      if ((in_valid && win_q.size() == WIN_LEN) || (flush && win_q.size() > 0)) begin
        m_sum = 0; m_max = 0; m_eq = 0;
        foreach (win_q[i]) begin
          if (win_q[i] == EQ_CODE) m_eq++;
          else begin
            m_sum += int'(win_q[i]);
            if (int'(win_q[i]) > m_max) m_max = int'(win_q[i]);
          end
        end
        if (m_sum > SUM_MAX) m_sum = SUM_MAX;
        m_cnt = win_q.size();
        win_q.delete();
        m_hold = 1'b1; m_valid = 1'b1;
      end
    end else if (out_ready) begin
      m_hold = 1'b0; m_valid = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("out_sum", int'(out_sum), m_sum);
      chk("out_max", int'(out_max), m_max);
      chk("out_eq_cnt", int'(out_eq_cnt), m_eq);
      chk("out_count", int'(out_count), m_cnt);
    end
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic f);
    in_valid = v;
    in_data  = v ? d : DATA_W'($urandom);
    flush    = f;
    @(negedge clk);
  endtask

  task automatic send_n(input int n, input logic [DATA_W-1:0] d);
    for (int i = 0; i < n; i++) drive(1'b1, d, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  // Wait (bounded) for a result, pin DUT and model against literals, then take it
  task automatic take_result(input string tag, input int es, input int em, input int ee, input int ec);
    int waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_timeout"}, int'(out_valid), 1);
    chk({tag, "_sum"}, int'(out_sum), es);
    chk({tag, "_max"}, int'(out_max), em);
    chk({tag, "_eq"}, int'(out_eq_cnt), ee);
    chk({tag, "_cnt"}, int'(out_count), ec);
    chk({tag, "_model_sum"}, m_sum, es);
    chk({tag, "_model_cnt"}, m_cnt, ec);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_after_take"}, int'(out_valid), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] fl_q[5];
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_sum", int'(out_sum), 0);
    chk("reset_ready", int'(in_ready), 1);
    RESET = 1'b0;
    @(negedge clk);

    send_n(16, 8'h03);
    take_result("full03", 48, 3, 0, 16);

    for (int i = 0; i < 16; i++) drive(1'b1, (i % 2 == 0) ? 8'hFF : 8'h10, 1'b0);
    take_result("alt_eq", 128, 16, 8, 16);

    send_n(16, 8'hFF);
    take_result("all_eq", 0, 0, 16, 16);

    fl_q = '{8'd1, 8'd9, 8'd4, 8'd2, 8'd7};
    for (int i = 0; i < 5; i++) drive(1'b1, fl_q[i], (i == 4) ? 1'b1 : 1'b0);
    chk("flush_latency", int'(out_valid), 1);
    take_result("flush5", 23, 9, 0, 5);

    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("empty_flush", int'(out_valid), 0);

    send_n(16, 8'hFE);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h55, 1'b1);
    chk("bp_ready", int'(in_ready), 0);
    drive(1'b0, 8'h00, 1'b0);
    take_result("max_fe", 4064, 254, 0, 16);

    send_n(7, 8'h22);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_sum", int'(out_sum), 0);
    send_n(16, 8'h01);
    take_result("after_rst", 16, 1, 0, 16);

    for (int i = 0; i < 600; i++) begin
      RESET     = ($urandom_range(0, 249) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 4) == 0) ? EQ_CODE : DATA_W'($urandom),
            $urandom_range(0, 15) == 0);
    end
    RESET = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/diff_window_stats.md
Name: diff_window_stats

Overview:
- Downstream consumer of the registered 8-bit magnitude-difference stream produced by the compare/subtract stage.
- Gathers WIN_LEN samples into a window and reports, per window: sum of differences, maximum difference, count of equality markers (EQ_CODE) and total sample count.
- Results are presented on a valid/ready output port and held until taken.

Parameters:
- DATA_W, 8, width of incoming difference samples.
- WIN_LEN, 16, samples per full window (≥2).
- SUM_W, 12, width of the sum accumulator (≥ DATA_W + clog2(WIN_LEN)).
- CNT_W, 5, width of the count outputs (must hold the value WIN_LEN).
- EQ_CODE, 8'hFF, sample value that marks an equal-operand event.

Ports:
- clk  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  DATA_W  difference sample.
- in_ready  out  1  block accepts a sample this cycle.
- flush  in  1  close the current partial window early.
- out_valid  out  1  window result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  SUM_W  sum of non-EQ_CODE samples in the window.
- out_max  out  DATA_W  maximum non-EQ_CODE sample; 0 if none.
- out_eq_cnt  out  CNT_W  number of EQ_CODE samples.
- out_count  out  CNT_W  total samples in the window.

Behaviour:
- Reset and clocking: clock is clk; reset is RESET, synchronous, active-high.
- Reset values: state=ACCUM, all accumulators 0, out_valid=0, out_sum/out_max/out_eq_cnt/out_count=0.
- Reset mid-window or while in HOLD discards all data; no partial result is emitted.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Take = out_valid & out_ready.
  - in_ready is decoded combinationally from state: 1 in ACCUM, 0 in HOLD.
  - out_valid is registered.
- State ACCUM, on accept:
  - If in_data == EQ_CODE: eq_acc += 1; sum and max are unchanged.
  - Otherwise: sum_acc += in_data, zero-extended to SUM_W; max_acc = max(max_acc, in_data).
  - cnt_acc += 1.
- Window close, in ACCUM:
  - Full window: the accept that makes cnt_acc == WIN_LEN.
  - Flush window: flush=1 and (cnt_acc > 0 or accept this cycle).
  - A sample accepted in the flush cycle is included in the window.
- On close, next cycle:
  - out_* are loaded with the final accumulated values, including the closing sample.
  - out_valid=1; state=HOLD.
  - Latency: out_valid rises 1 cycle after the closing accept/flush.
- flush with cnt_acc == 0 and no accept: ignored, no empty window is emitted.
- flush in HOLD: ignored, not remembered.
- State HOLD:
  - in_ready=0.
  - out_* are stable until take.
  - On take: out_valid=0, accumulators cleared, state=ACCUM.
  - in_ready=1 from the cycle after the take; a sample cannot be accepted in the take cycle.
- out_ready while out_valid=0 has no effect.
- Arithmetic: with parameters legal, the sum cannot overflow. Implementation must still saturate out_sum at all-ones rather than wrap.
- in_data must only be sampled on accept; X on in_data while not accepting must not disturb state.

Test Plan:
- Full window, normal data: 16 samples of 8'h03, out_ready=1 → out_valid 1 cycle after the 16th accept; sum=48, max=3, eq_cnt=0, count=16; in_ready=0 for exactly the take cycle.
- Equality markers: 16 samples, alternating 8'hFF / 8'h10 → sum=128, max=16, eq_cnt=8, count=16; all-EQ_CODE window → sum=0, max=0, eq_cnt=16.
- Flush: 5 samples {1,9,4,2,7}, flush asserted with the 5th sample → sum=23, max=9, count=5 next cycle. flush with empty window → no out_valid, ever.
- Backpressure: out_ready=0 for 10 cycles after a window closes → out_valid held, outputs stable, in_ready=0, in_valid=1 samples not accepted. After the take, the next window starts clean.
- Max value: 16 samples of 8'hFE → sum=4064 (12'hFE0), max=254; with SUM_W=12 no saturation occurs.
- Reset mid-window: 7 samples, RESET for 1 cycle, then 16 samples of 8'h01 → single result: sum=16, count=16; all outputs 0 during and after reset until close.
